// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM encoding, forwarding selects and
// architectural register constants.
package core_pkg;

   typedef enum logic [1:0] {
      HZ_IDLE  = 2'd0,
      HZ_MBUSY = 2'd1,
      HZ_MDONE = 2'd2
   } hz_state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface hazard_ctrl_unit_if;

   logic [3:0] RA1D, RA2D, RA1E, RA2E;
   logic [3:0] WA3E, WA3M, WA3W;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemtoRegE, PCSrcE, M_StartE, MDone;

   logic       StallF, StallD, FlushD, StallE, FlushE, FlushM;
   logic [1:0] ForwardAE, ForwardBE;

   modport master (
      output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcE, M_StartE, MDone,
      input  StallF, StallD, FlushD, StallE, FlushE, FlushM, ForwardAE, ForwardBE
   );

   modport slave (
      input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcE, M_StartE, MDone,
      output StallF, StallD, FlushD, StallE, FlushE, FlushM, ForwardAE, ForwardBE
   );

endinterface

// File: rtl/hazard_fwd_sel.sv
// E-stage operand forwarding select for one source register; M result wins
// over W result and the PC is never forwarded.
module hazard_fwd_sel
   import core_pkg::*;
(
   input  logic [3:0] ra_i,
   input  logic [3:0] wa3m_i,
   input  logic [3:0] wa3w_i,
   input  logic       reg_write_m_i,
   input  logic       reg_write_w_i,
   output logic [1:0] fwd_o
);

   // NOTE: assigning a default before any branch keeps this block free of inferred latches.
   always_comb begin
      fwd_o = FWD_RF;
      if (ra_i != REG_PC) begin
         if (reg_write_m_i && (wa3m_i == ra_i)) begin
            fwd_o = FWD_M;
         end else if (reg_write_w_i && (wa3w_i == ra_i)) begin
            fwd_o = FWD_W;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes, operand
// forwarding and sequencing of multi-cycle MUL/DIV ops with a watchdog.
module hazard_ctrl_unit
   import core_pkg::*;
#(
   parameter int MAX_MCYCLE = 40,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_p,
   hazard_ctrl_unit_if.slave hz,
   output logic             mcycle_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int              WD_W    = $clog2(MAX_MCYCLE + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_MCYCLE - 1);

   hz_state_e        state_q;
   logic [WD_W-1:0]  wd_q;
   logic             timeout_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic       ldr_stall;
   logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
   logic [1:0] fwd_a, fwd_b;

   hazard_fwd_sel u_fwd_a (
      .ra_i         (hz.RA1E),
      .wa3m_i       (hz.WA3M),
      .wa3w_i       (hz.WA3W),
      .reg_write_m_i(hz.RegWriteM),
      .reg_write_w_i(hz.RegWriteW),
      .fwd_o        (fwd_a)
   );

   hazard_fwd_sel u_fwd_b (
      .ra_i         (hz.RA2E),
      .wa3m_i       (hz.WA3M),
      .wa3w_i       (hz.WA3W),
      .reg_write_m_i(hz.RegWriteM),
      .reg_write_w_i(hz.RegWriteW),
      .fwd_o        (fwd_b)
   );

   assign ldr_stall = hz.MemtoRegE && hz.RegWriteE &&
                      ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));

   // The start cycle already stalls so the op holds E while MBUSY is entered.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      if (!rst_p) begin
         case (state_q)
            HZ_IDLE: begin
               flush_d = hz.PCSrcE;
               if (hz.M_StartE) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  stall_e = 1'b1;
               end else begin
                  stall_f = ldr_stall;
                  stall_d = ldr_stall;
                  flush_e = ldr_stall || hz.PCSrcE;
               end
            end
            HZ_MBUSY: begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               flush_m = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst_p) begin
         state_q     <= HZ_IDLE;
         wd_q        <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         case (state_q)
            HZ_IDLE: begin
               wd_q <= '0;
               if (hz.M_StartE) begin
                  state_q <= HZ_MBUSY;
               end
            end
            HZ_MBUSY: begin
               if (hz.MDone) begin
                  state_q <= HZ_MDONE;
               end else if (wd_q == WD_LAST) begin
                  state_q   <= HZ_IDLE;
                  timeout_q <= 1'b1;
                  wd_q      <= '0;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            default: begin
               state_q <= HZ_IDLE;
               wd_q    <= '0;
            end
         endcase
      end
   end

   assign hz.StallF    = stall_f;
   assign hz.StallD    = stall_d;
   assign hz.StallE    = stall_e;
   assign hz.FlushD    = flush_d;
   assign hz.FlushE    = flush_e;
   assign hz.FlushM    = flush_m;
   assign hz.ForwardAE = rst_p ? FWD_RF : fwd_a;
   assign hz.ForwardBE = rst_p ? FWD_RF : fwd_b;

   assign mcycle_timeout = timeout_q;
   assign stall_cycles   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_hazard_ctrl_unit;
   import core_pkg::*;

   localparam int MAX_MCYCLE = 40;
   localparam int CNT_W      = 6;
   localparam int SAT        = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_p;
   logic             mcycle_timeout;
   logic [CNT_W-1:0] stall_cycles;

   int n_cmp = 0;
   int n_bad = 0;

   hazard_ctrl_unit_if hz_if ();

   hazard_ctrl_unit #(
      .MAX_MCYCLE(MAX_MCYCLE),
      .CNT_W     (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_p         (rst_p),
      .hz            (hz_if),
      .mcycle_timeout(mcycle_timeout),
      .stall_cycles  (stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       sf, sd, se, fd, fe, fm;
      bit [1:0] fa, fb;
   } exp_t;

   // Behavioural model state
   bit m_busy, m_done, m_timeout;
   int m_busy_n, m_stalls;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit [1:0] fwd_ref(input logic [3:0] ra);
      if (ra == 4'd15) return 2'b00;
      if (hz_if.RegWriteM && hz_if.WA3M == ra) return 2'b10;
      if (hz_if.RegWriteW && hz_if.WA3W == ra) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      bit   ldr;
      e   = '{default: 0};
      ldr = hz_if.MemtoRegE && hz_if.RegWriteE &&
            (hz_if.WA3E == hz_if.RA1D || hz_if.WA3E == hz_if.RA2D);
      if (rst_p) return e;
      e.fa = fwd_ref(hz_if.RA1E);
      e.fb = fwd_ref(hz_if.RA2E);
      if (m_done) begin
         // result cycle: everything released
      end else if (m_busy) begin
         e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
      end else if (hz_if.M_StartE) begin
         e.sf = 1; e.sd = 1; e.se = 1; e.fd = hz_if.PCSrcE;
      end else begin
         e.sf = ldr; e.sd = ldr; e.fd = hz_if.PCSrcE; e.fe = ldr || hz_if.PCSrcE;
      end
      return e;
   endfunction

   task automatic cycle();
      exp_t e;
      @(negedge clk);
      e = model_out();
      check("StallF", hz_if.StallF, e.sf);
      check("StallD", hz_if.StallD, e.sd);
      check("StallE", hz_if.StallE, e.se);
      check("FlushD", hz_if.FlushD, e.fd);
      check("FlushE", hz_if.FlushE, e.fe);
      check("FlushM", hz_if.FlushM, e.fm);
      check("ForwardAE", hz_if.ForwardAE, e.fa);
      check("ForwardBE", hz_if.ForwardBE, e.fb);
      check("mcycle_timeout", mcycle_timeout, m_timeout);
      check("stall_cycles", stall_cycles, m_stalls);
      check("FlushE_and_StallE", hz_if.FlushE && hz_if.StallE, 0);
      @(posedge clk);
      if (rst_p) begin
         m_busy = 0; m_done = 0; m_timeout = 0; m_busy_n = 0; m_stalls = 0;
      end else begin
         if (e.sf && m_stalls < SAT) m_stalls++;
         if (m_done) begin
            m_done = 0;
         end else if (m_busy) begin
            m_busy_n++;
            if (hz_if.MDone) begin
               m_busy = 0; m_done = 1;
            end else if (m_busy_n == MAX_MCYCLE) begin
               m_busy = 0; m_timeout = 1;
            end
         end else if (hz_if.M_StartE) begin
            m_busy = 1; m_busy_n = 0;
         end
      end
      #1;
   endtask

   task automatic clear_inputs();
      hz_if.RA1D = 0; hz_if.RA2D = 0; hz_if.RA1E = 0; hz_if.RA2E = 0;
      hz_if.WA3E = 0; hz_if.WA3M = 0; hz_if.WA3W = 0;
      hz_if.RegWriteE = 0; hz_if.RegWriteM = 0; hz_if.RegWriteW = 0;
      hz_if.MemtoRegE = 0; hz_if.PCSrcE = 0; hz_if.M_StartE = 0; hz_if.MDone = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_p = 1;
      cycle();
      rst_p = 0;
   endtask

   function automatic logic [3:0] rnd_reg();
      if ($urandom_range(0, 7) == 0) return 4'd15;
      return 4'($urandom_range(0, 7));
   endfunction

   initial begin
      int base, n_se, n_fm, n_st;

      clear_inputs();
      m_busy = 0; m_done = 0; m_timeout = 0; m_busy_n = 0; m_stalls = 0;
      rst_p = 1;
      @(posedge clk);
      #1;
      hz_if.MemtoRegE = 1; hz_if.RegWriteE = 1; hz_if.PCSrcE = 1; hz_if.M_StartE = 1;
      cycle();
      check("lit_reset_stall_cycles", stall_cycles, 0);
      check("lit_reset_timeout", mcycle_timeout, 0);
      clear_inputs();
      rst_p = 0;

      // Forwarding priority and PC exclusion
      hz_if.RegWriteM = 1; hz_if.WA3M = 3; hz_if.RegWriteW = 1; hz_if.WA3W = 3; hz_if.RA1E = 3;
      #1;
      check("lit_fwdA_M_priority", hz_if.ForwardAE, 2'b10);
      cycle();
      hz_if.RA1E = 15;
      #1;
      check("lit_fwdA_pc", hz_if.ForwardAE, 2'b00);
      cycle();
      hz_if.RegWriteM = 0; hz_if.RA2E = 3;
      #1;
      check("lit_fwdB_W", hz_if.ForwardBE, 2'b01);
      cycle();
      clear_inputs();

      // Load-use stall
      base = int'(stall_cycles);
      hz_if.MemtoRegE = 1; hz_if.RegWriteE = 1; hz_if.WA3E = 5; hz_if.RA2D = 5; hz_if.RA1D = 1;
      #1;
      check("lit_ldr_StallF", hz_if.StallF, 1);
      check("lit_ldr_StallD", hz_if.StallD, 1);
      check("lit_ldr_FlushE", hz_if.FlushE, 1);
      check("lit_ldr_StallE", hz_if.StallE, 0);
      cycle();
      clear_inputs();
      check("lit_ldr_count", stall_cycles, base + 1);

      // Branch flush in IDLE
      hz_if.PCSrcE = 1;
      #1;
      check("lit_br_FlushD", hz_if.FlushD, 1);
      check("lit_br_FlushE", hz_if.FlushE, 1);
      check("lit_br_StallF", hz_if.StallF, 0);
      cycle();
      clear_inputs();

      // Multi-cycle op completing after 7 busy cycles
      do_reset();
      n_se = 0; n_fm = 0;
      for (int i = 0; i < 8; i++) begin
         hz_if.M_StartE = (i == 0);
         hz_if.MDone    = (i == 7);
         hz_if.PCSrcE   = (i == 3);
         #1;
         if (hz_if.StallE) n_se++;
         if (hz_if.FlushM) n_fm++;
         if (i == 3) check("lit_busy_no_FlushD", hz_if.FlushD, 0);
         cycle();
      end
      clear_inputs();
      #1;
      check("lit_mdone_StallF", hz_if.StallF, 0);
      check("lit_mdone_StallE", hz_if.StallE, 0);
      check("lit_mdone_FlushM", hz_if.FlushM, 0);
      cycle();
      check("lit_mul_StallE_cycles", n_se, 8);
      check("lit_mul_FlushM_cycles", n_fm, 7);
      check("lit_mul_stall_count", stall_cycles, 8);
      hz_if.MDone = 1;
      cycle();
      clear_inputs();
      cycle();

      // Watchdog: two ops that never complete (second also saturates counter)
      do_reset();
      for (int op = 0; op < 2; op++) begin
         n_st = 0;
         for (int k = 0; k < 60; k++) begin
            hz_if.M_StartE = (k == 0);
            #1;
            if (hz_if.StallE) n_st++;
            cycle();
         end
         check("lit_wd_stalled_cycles", n_st, 41);
         check("lit_wd_timeout", mcycle_timeout, 1);
         check("lit_wd_count", stall_cycles, (op == 0) ? 41 : SAT);
      end
      clear_inputs();

      // Reset in the middle of a busy op
      hz_if.M_StartE = 1;
      cycle();
      clear_inputs();
      repeat (5) cycle();
      rst_p = 1;
      cycle();
      rst_p = 0;
      #1;
      check("lit_midrst_StallF", hz_if.StallF, 0);
      check("lit_midrst_StallE", hz_if.StallE, 0);
      check("lit_midrst_FlushM", hz_if.FlushM, 0);
      check("lit_midrst_count", stall_cycles, 0);
      check("lit_midrst_timeout", mcycle_timeout, 0);
      cycle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         hz_if.RA1D = rnd_reg(); hz_if.RA2D = rnd_reg();
         hz_if.RA1E = rnd_reg(); hz_if.RA2E = rnd_reg();
         hz_if.WA3E = rnd_reg(); hz_if.WA3M = rnd_reg(); hz_if.WA3W = rnd_reg();
         hz_if.RegWriteE = 1'($urandom_range(0, 1));
         hz_if.RegWriteM = 1'($urandom_range(0, 1));
         hz_if.RegWriteW = 1'($urandom_range(0, 1));
         hz_if.MemtoRegE = ($urandom_range(0, 9) < 3);
         hz_if.PCSrcE    = ($urandom_range(0, 19) < 3);
         hz_if.M_StartE  = ($urandom_range(0, 99) < 8);
         hz_if.MDone     = ($urandom_range(0, 9) == 0);
         rst_p           = ($urandom_range(0, 299) == 0);
         cycle();
      end
      rst_p = 0;
      clear_inputs();
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL sim_time_limit: got timeout, expected completion");
      $fatal(1, "simulation time limit");
   end

endmodule
